sram_rr_arbiter: RTL and testbench
==================================

// Module: sram_rr_arbiter
// PURPOSE
//  Shares the single off-chip async SRAM (16-bit, 1M-word) between two requesters: port A (audio sample
//  buffer) and port B (CPU/DMA bridge). Round-robin arbitration, one transaction at a time, fixed-timing
//  SETUP/ACCESS/HOLD sequencing of CE_N/OE_N/WE_N/LB_N/UB_N. Sits between fabric masters and the sram_* pins.
// PARAMETERS
//  ADDR_W         20  SRAM word-address width
//  DATA_W         16  SRAM data width (byte lanes = DATA_W/8 = 2)
//  ACCESS_CYCLES  2   cycles the OE_N/WE_N strobe is held low; legal range 1..15
// PORTS
//  clk_clk        in   1       system clock; single clock domain
//  reset_reset_n  in   1       synchronous, active-low reset
//  a_req, b_req   in   1       request; held high with stable cmd until grant is seen
//  a_we, b_we     in   1       1 = write, 0 = read
//  a_addr, b_addr in   ADDR_W  word address
//  a_wdata,b_wdata in  DATA_W  write data
//  a_be, b_be     in   2       byte enables (bit0 = low byte); writes only
//  a_gnt, b_gnt   out  1       one-cycle accept pulse; command captured this cycle
//  a_rvalid,b_rvalid out 1     one-cycle pulse, rdata valid (reads only)
//  rdata          out  DATA_W  shared read-data register; qualify with the rvalid for the port
//  sram_DQ        inout DATA_W SRAM data bus
//  sram_ADDR      out  ADDR_W  SRAM address
//  sram_LB_N, sram_UB_N, sram_CE_N, sram_OE_N, sram_WE_N  out 1  SRAM controls, active low
// BEHAVIOUR
//  Reset (sync, active-low): state=IDLE; CE_N/OE_N/WE_N/LB_N/UB_N=1; ADDR=0; DQ high-Z; gnt/rvalid=0;
//   rdata=0; last_grant=B (so A wins the first tie). Reset mid-transaction aborts it at that edge:
//   strobes deassert, DQ releases, no rvalid issued.
//  FSM: IDLE -> SETUP -> ACCESS (ACCESS_CYCLES cycles, down-counter) -> HOLD -> IDLE.
//   IDLE: if any req, pick winner, gnt combinational high this cycle, latch we/addr/wdata/be/owner.
//    Winner: only one req -> it; both -> the port not in last_grant; last_grant updated on every grant.
//   SETUP: ADDR valid, CE_N=0; write: DQ driven, LB_N/UB_N=~be; read: LB_N=UB_N=0, DQ Z, OE_N=0.
//   ACCESS: read: OE_N=0; write: WE_N=0 only if be!=00 (be=00 write runs full timing, no WE pulse).
//    Read data sampled into rdata on the edge ending the last ACCESS cycle.
//   HOLD: WE_N/OE_N=1, ADDR/CE_N/DQ unchanged (write data hold); read: owner's rvalid=1 this cycle.
//   Next IDLE: CE_N=1, LB_N/UB_N=1, DQ Z. Requests pending during a transaction wait; no gnt outside IDLE.
//  All sram_* outputs and DQ output-enable are registered (no combinational paths to pins).
//  Timing per transaction (ACCESS_CYCLES=N): gnt at cycle 0, SETUP 1, ACCESS 2..N+1, HOLD N+2
//   (rvalid), IDLE N+3 -> next gnt earliest cycle N+3. Throughput one access per N+3 cycles.
//  WE_N and OE_N never low simultaneously; DQ never driven while OE_N=0.
//  req dropped before gnt: legal, no transaction. req after gnt: treated as a new request.
// STRUCTURE
//  sram_arb_pkg: state enum {IDLE,SETUP,ACCESS,HOLD}; PORT_A=0/PORT_B=1 constants; ACCESS_CYCLES
//   range check function.
//  Sub-module rr_arbiter2: 2-way round-robin picker (req[1:0], advance, last_grant reg -> gnt[1:0]).
//  Top: FSM, access counter, command latch, rdata register, DQ tri-state.
// TESTING (bench uses SRAM behavioural model with address/data checks)
//  Reset: hold reset_reset_n=0 3 cycles -> all SRAM controls 1, DQ Z, gnt/rvalid 0, rdata 0.
//  A write 0x00010=0xBEEF be=11, then A read 0x00010 -> a_gnt cycle 0, WE_N low cycles 2-3,
//   a_rvalid at cycle 4 of read with rdata=0xBEEF; b_rvalid never asserts.
//  a_req and b_req rise same cycle, both held -> order A,B,A,B by grants; grants 5 cycles apart (N=2).
//  Byte write be=01 data 0x1234 over 0xBEEF at 0x00010, read back -> 0xBE34; be=00 write -> no WE pulse.
//  Reset asserted during ACCESS of a write -> WE_N/CE_N high next edge, DQ Z, no rvalid, next tie grants A.
//  ACCESS_CYCLES=1 and 15 rebuilds -> rvalid at cycle 3 and 17 after gnt; WE_N/OE_N never overlap.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the two-port async SRAM arbiter:
//   - FSM state encodings for the SETUP/ACCESS/HOLD sequencer
//   - requester index constants (bit positions in the 2-bit req/gnt vectors)
//   - ACCESS_CYCLES range check and counter-load helper
// ---------------------------------------------------------------------------
package sram_arb_pkg;

  // Sequencer states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Requester indices: bit 0 of req/gnt is port A, bit 1 is port B
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Strobe-width limits; the down-counter is 4 bits wide
  localparam int ACCESS_MIN = 1;
  localparam int ACCESS_MAX = 15;

  function automatic bit access_cycles_legal(input int n);
    return (n >= ACCESS_MIN) && (n <= ACCESS_MAX);
  endfunction

  // Counter load value; an out-of-range parameter is clamped to the nearest
  // legal strobe width so the sequencer can never stall or wrap.
  function automatic logic [3:0] access_cycles_load(input int n);
    if (access_cycles_legal(n)) begin
      return 4'(n);
    end else if (n < ACCESS_MIN) begin
      return 4'(ACCESS_MIN);
    end else begin
      return 4'(ACCESS_MAX);
    end
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin picker. The grant vector is combinational from the
// request vector and the remembered last winner; the last winner register
// only moves when the caller is actually accepting a grant (i_advance).
// Ports:
//   i_clk      clock
//   i_rst_n    synchronous active-low reset (last winner := port B)
//   i_req[1:0] requests, bit 0 = port A, bit 1 = port B
//   i_advance  high when the grant is being consumed this cycle
//   o_gnt[1:0] one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module rr_arbiter2
  import sram_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  logic r_last;
  logic [1:0] w_gnt;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    w_gnt = 2'b00;
    case (i_req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = (r_last == PORT_B) ? 2'b01 : 2'b10;
      default: w_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_last <= PORT_B;
    end else if (i_advance && (w_gnt != 2'b00)) begin
      r_last <= w_gnt[1];
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/sram_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sram_rr_arbiter
// Shares one 16-bit asynchronous SRAM between two fabric requesters (A: audio
// sample buffer, B: CPU/DMA bridge). One transaction at a time, round-robin
// on ties, fixed SETUP / ACCESS(ACCESS_CYCLES) / HOLD strobe sequencing.
// Every sram_* pin and the DQ output enable come straight from flops.
// Ports:
//   clk_clk, reset_reset_n            clock, synchronous active-low reset
//   {a,b}_req/_we/_addr/_wdata/_be    request and command, held until gnt
//   {a,b}_gnt                         combinational accept pulse (IDLE only)
//   {a,b}_rvalid                      one-cycle read-data-valid pulse
//   rdata                             shared read-data register
//   sram_DQ                           bidirectional SRAM data bus
//   sram_ADDR, sram_LB_N, sram_UB_N,
//   sram_CE_N, sram_OE_N, sram_WE_N   SRAM address and active-low controls
// ---------------------------------------------------------------------------
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_wdata,
  input  logic [DATA_W/8-1:0] b_be,
  output logic                a_gnt,
  output logic                b_gnt,
  output logic                a_rvalid,
  output logic                b_rvalid,
  output logic [DATA_W-1:0]   rdata,
  inout  wire  [DATA_W-1:0]   sram_DQ,
  output logic [ADDR_W-1:0]   sram_ADDR,
  output logic                sram_LB_N,
  output logic                sram_UB_N,
  output logic                sram_CE_N,
  output logic                sram_OE_N,
  output logic                sram_WE_N
);

  localparam int         BE_W     = DATA_W / 8;
  localparam logic [3:0] CNT_LOAD = access_cycles_load(ACCESS_CYCLES);

  // Sequencer and command latch
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic              r_owner;

  // Pin registers
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_dq_out;
  logic              r_dq_oe;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_lb_n;
  logic              r_ub_n;

  // Read return
  logic [DATA_W-1:0] r_rdata;
  logic              r_a_rvalid;
  logic              r_b_rvalid;

  // Arbitration and selected command
  logic              w_idle;
  logic [1:0]        w_arb_gnt;
  logic [1:0]        w_gnt;
  logic              w_sel_b;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_be;

  assign w_idle = (r_state == ST_IDLE);

  rr_arbiter2 u_rr (
    .i_clk     (clk_clk),
    .i_rst_n   (reset_reset_n),
    .i_req     ({b_req, a_req}),
    .i_advance (w_idle),
    .o_gnt     (w_arb_gnt)
  );

  // Grants are only offered while the sequencer is idle.
  assign w_gnt   = w_idle ? w_arb_gnt : 2'b00;
  assign w_sel_b = w_gnt[1];
  assign w_we    = w_sel_b ? b_we    : a_we;
  assign w_addr  = w_sel_b ? b_addr  : a_addr;
  assign w_wdata = w_sel_b ? b_wdata : a_wdata;
  assign w_be    = w_sel_b ? b_be    : a_be;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_owner     <= PORT_A;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_rdata     <= '0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
    end else begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      case (r_state)
        // IDLE -> SETUP: capture the winner's command and present address,
        // chip enable and (for writes) data and byte lanes.
        ST_IDLE: begin
          if (w_gnt != 2'b00) begin
            r_state     <= ST_SETUP;
            r_we        <= w_we;
            r_be        <= w_be;
            r_owner     <= w_sel_b;
            r_sram_addr <= w_addr;
            r_ce_n      <= 1'b0;
            if (w_we) begin
              r_dq_out <= w_wdata;
              r_dq_oe  <= 1'b1;
              r_lb_n   <= ~w_be[0];
              r_ub_n   <= ~w_be[1];
            end else begin
              r_dq_oe  <= 1'b0;
              r_lb_n   <= 1'b0;
              r_ub_n   <= 1'b0;
              r_oe_n   <= 1'b0;
            end
          end
        end
        // SETUP -> ACCESS: load the strobe counter; a write with no byte
        // lanes enabled keeps the timing but never pulses WE_N.
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          r_cnt   <= CNT_LOAD;
          if (r_we && (r_be != '0)) begin
            r_we_n <= 1'b0;
          end
        end
        // ACCESS -> HOLD: on the edge ending the last strobe cycle, sample
        // read data while OE_N is still low, then release the strobes.
        ST_ACCESS: begin
          if (r_cnt == 4'd1) begin
            r_state <= ST_HOLD;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            if (!r_we) begin
              r_rdata    <= sram_DQ;
              r_a_rvalid <= (r_owner == PORT_A);
              r_b_rvalid <= (r_owner == PORT_B);
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        // HOLD -> IDLE: address, CE_N and write data were held one cycle
        // past the strobe; now release the chip and the bus.
        ST_HOLD: begin
          r_state <= ST_IDLE;
          r_ce_n  <= 1'b1;
          r_lb_n  <= 1'b1;
          r_ub_n  <= 1'b1;
          r_dq_oe <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sram_DQ   = r_dq_oe ? r_dq_out : {DATA_W{1'bz}};
  assign sram_ADDR = r_sram_addr;
  assign sram_CE_N = r_ce_n;
  assign sram_OE_N = r_oe_n;
  assign sram_WE_N = r_we_n;
  assign sram_LB_N = r_lb_n;
  assign sram_UB_N = r_ub_n;
  assign a_gnt     = w_gnt[0];
  assign b_gnt     = w_gnt[1];
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign rdata     = r_rdata;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
module tb_sram_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic mem_clear = 1'b1;

  // main DUT
  logic a_req = 1'b0, b_req = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic [1:0] a_be = '0, b_be = '0;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] rdata;
  wire  [DW-1:0] sram_DQ;
  logic [AW-1:0] sram_ADDR;
  logic lb_n, ub_n, ce_n, oe_n, we_n;

  sram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(N)) u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .rdata(rdata), .sram_DQ(sram_DQ), .sram_ADDR(sram_ADDR),
    .sram_LB_N(lb_n), .sram_UB_N(ub_n), .sram_CE_N(ce_n), .sram_OE_N(oe_n), .sram_WE_N(we_n)
  );

  // SRAM pin model for the main DUT
  logic [DW-1:0] sram_mem [0:255];
  assign sram_DQ = (!ce_n && !oe_n && we_n) ? sram_mem[sram_ADDR[7:0]] : {DW{1'bz}};
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= '0;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) sram_mem[sram_ADDR[7:0]][7:0]  <= sram_DQ[7:0];
      if (!ub_n) sram_mem[sram_ADDR[7:0]][15:8] <= sram_DQ[15:8];
    end
  end

  // ACCESS_CYCLES=1 and 15 instances, port A reads only
  logic x1_req = 1'b0, x15_req = 1'b0, zb = 1'b0;
  logic [AW-1:0] x_addr = 20'h00005, zaddr = '0;
  logic [DW-1:0] zdata = '0;
  logic [1:0] zbe = '0;
  logic x1_gnt, x1_bgnt, x1_rv, x1_brv, x1_lb_n, x1_ub_n, x1_ce_n, x1_oe_n, x1_we_n;
  logic x15_gnt, x15_bgnt, x15_rv, x15_brv, x15_lb_n, x15_ub_n, x15_ce_n, x15_oe_n, x15_we_n;
  logic [DW-1:0] x1_rdata, x15_rdata;
  logic [AW-1:0] x1_ADDR, x15_ADDR;
  wire  [DW-1:0] x1_DQ, x15_DQ;
  assign x1_DQ  = (!x1_ce_n && !x1_oe_n && x1_we_n)    ? 16'hA5A5 : {DW{1'bz}};
  assign x15_DQ = (!x15_ce_n && !x15_oe_n && x15_we_n) ? 16'h5A5A : {DW{1'bz}};

  sram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) u_dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .a_req(x1_req), .a_we(zb), .a_addr(x_addr), .a_wdata(zdata), .a_be(zbe),
    .b_req(zb), .b_we(zb), .b_addr(zaddr), .b_wdata(zdata), .b_be(zbe),
    .a_gnt(x1_gnt), .b_gnt(x1_bgnt), .a_rvalid(x1_rv), .b_rvalid(x1_brv),
    .rdata(x1_rdata), .sram_DQ(x1_DQ), .sram_ADDR(x1_ADDR),
    .sram_LB_N(x1_lb_n), .sram_UB_N(x1_ub_n), .sram_CE_N(x1_ce_n), .sram_OE_N(x1_oe_n), .sram_WE_N(x1_we_n)
  );

  sram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(15)) u_dut15 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .a_req(x15_req), .a_we(zb), .a_addr(x_addr), .a_wdata(zdata), .a_be(zbe),
    .b_req(zb), .b_we(zb), .b_addr(zaddr), .b_wdata(zdata), .b_be(zbe),
    .a_gnt(x15_gnt), .b_gnt(x15_bgnt), .a_rvalid(x15_rv), .b_rvalid(x15_brv),
    .rdata(x15_rdata), .sram_DQ(x15_DQ), .sram_ADDR(x15_ADDR),
    .sram_LB_N(x15_lb_n), .sram_UB_N(x15_ub_n), .sram_CE_N(x15_ce_n), .sram_OE_N(x15_oe_n), .sram_WE_N(x15_we_n)
  );

  // bookkeeping
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: one transaction timeline plus expected memory contents
  int            t_g = -1;
  logic          t_we = 1'b0, t_own = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [1:0]    t_be = '0;
  logic [DW-1:0] t_wdata = '0, t_rexp = '0;
  logic          last_b = 1'b1;
  logic [DW-1:0] exp_rdata = '0;
  logic [DW-1:0] ref_mem [0:255];

  int            ev_gnt;
  logic          ev_rv;
  logic [DW-1:0] ev_rdata;
  logic          ev1_g, ev1_rv, ev15_g, ev15_rv;
  logic [DW-1:0] ev1_d, ev15_d;
  int            we_low_cnt = 0, rva_cnt = 0, rvb_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Called at the falling edge of every cycle.
  task automatic check_cycle();
    int   rel;
    logic act, win_b, ega, egb;
    rel = cyc - t_g;
    act = (t_g >= 0) && (rel >= 1) && (rel <= N + 2);
    if (act && !t_we && rel == N + 2) exp_rdata = t_rexp;
    chk("ce_n", ce_n, !act);
    chk("oe_n", oe_n, !(act && !t_we && rel <= N + 1));
    chk("we_n", we_n, !(act && t_we && (t_be != 2'b00) && rel >= 2 && rel <= N + 1));
    chk("lb_n", lb_n, act ? (t_we ? !t_be[0] : 1'b0) : 1'b1);
    chk("ub_n", ub_n, act ? (t_we ? !t_be[1] : 1'b0) : 1'b1);
    chk("a_rvalid", a_rvalid, act && !t_we && !t_own && rel == N + 2);
    chk("b_rvalid", b_rvalid, act && !t_we && t_own && rel == N + 2);
    chk("rdata", rdata, exp_rdata);
    if (act) begin
      chk("sram_addr", sram_ADDR, t_addr);
      if (t_we) chk("dq_wdata", sram_DQ, t_wdata);
    end
    ega = 1'b0;
    egb = 1'b0;
    if ((t_g < 0 || rel >= N + 3) && (a_req || b_req)) begin
      win_b   = b_req && (!a_req || !last_b);
      ega     = !win_b;
      egb     = win_b;
      last_b  = win_b;
      t_g     = cyc;
      t_own   = win_b;
      t_we    = win_b ? b_we : a_we;
      t_addr  = win_b ? b_addr : a_addr;
      t_wdata = win_b ? b_wdata : a_wdata;
      t_be    = win_b ? b_be : a_be;
      if (t_we) begin
        if (t_be[0]) ref_mem[t_addr[7:0]][7:0]  = t_wdata[7:0];
        if (t_be[1]) ref_mem[t_addr[7:0]][15:8] = t_wdata[15:8];
      end else begin
        t_rexp = ref_mem[t_addr[7:0]];
      end
    end
    chk("a_gnt", a_gnt, ega);
    chk("b_gnt", b_gnt, egb);
    // secondary instances: strobes exclusive, B side silent, address/lanes right
    chk("x1_overlap", !x1_we_n && !x1_oe_n, 1'b0);
    chk("x15_overlap", !x15_we_n && !x15_oe_n, 1'b0);
    chk("x1_bside", {x1_bgnt, x1_brv}, 2'b00);
    chk("x15_bside", {x15_bgnt, x15_brv}, 2'b00);
    if (!x1_ce_n)  chk("x1_pins",  {x1_ADDR, x1_lb_n, x1_ub_n},   {x_addr, 2'b00});
    if (!x15_ce_n) chk("x15_pins", {x15_ADDR, x15_lb_n, x15_ub_n}, {x_addr, 2'b00});
    // events for the directed steps
    ev_gnt   = a_gnt ? 1 : (b_gnt ? 2 : 0);
    ev_rv    = a_rvalid || b_rvalid;
    ev_rdata = rdata;
    ev1_g  = x1_gnt;  ev1_rv  = x1_rv;  ev1_d  = x1_rdata;
    ev15_g = x15_gnt; ev15_rv = x15_rv; ev15_d = x15_rdata;
    if (!we_n) we_low_cnt++;
    if (a_rvalid) rva_cnt++;
    if (b_rvalid) rvb_cnt++;
    if (!rst_n) begin
      t_g       = -1;
      last_b    = 1'b1;
      exp_rdata = '0;
    end
  endtask

  // One clock: check at negedge, then step to just after the next posedge.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (ev_gnt == 1) a_req = 1'b0;
    if (ev_gnt == 2) b_req = 1'b0;
    if (ev1_g)  x1_req  = 1'b0;
    if (ev15_g) x15_req = 1'b0;
  endtask

  task automatic set_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [1:0] be);
    a_we = we; a_addr = addr; a_wdata = d; a_be = be; a_req = 1'b1;
  endtask

  task automatic set_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic [1:0] be);
    b_we = we; b_addr = addr; b_wdata = d; b_be = be; b_req = 1'b1;
  endtask

  task automatic wait_gnt(output int port, output int gc);
    port = 0;
    gc   = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ev_gnt != 0) begin
        port = ev_gnt;
        gc   = cyc - 1;
        break;
      end
    end
    if (port == 0) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rv(output int rc, output logic [DW-1:0] d);
    rc = -1000;
    d  = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ev_rv) begin
        rc = cyc - 1;
        d  = ev_rdata;
        break;
      end
    end
    if (rc < 0) chk("rvalid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int n);
    a_req = 1'b0;
    b_req = 1'b0;
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int            p, g0, g1, rc, g1c, r1c, g15c, r15c;
    logic [DW-1:0] d, d1, d15;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // reset held 3 cycles
    @(posedge clk);
    #1;
    mem_clear = 1'b0;
    chk("rst_addr", sram_ADDR, '0);
    do_reset(3);

    // A write 0x00010 = 0xBEEF, then A read it back
    rvb_cnt    = 0;
    we_low_cnt = 0;
    set_a(1'b1, 20'h00010, 16'hBEEF, 2'b11);
    wait_gnt(p, g0);
    chk("beef_wr_port", p, 1);
    set_a(1'b0, 20'h00010, 16'h0000, 2'b00);
    wait_gnt(p, g1);
    chk("beef_rd_port", p, 1);
    chk("beef_gnt_spacing", g1 - g0, N + 3);
    chk("beef_we_low_cycles", we_low_cnt, N);
    wait_rv(rc, d);
    chk("beef_rv_latency", rc - g1, N + 2);
    chk("beef_rdata", d, 16'hBEEF);

    // byte write over 0xBEEF, then a write with no lanes enabled
    set_a(1'b1, 20'h00010, 16'h1234, 2'b01);
    wait_gnt(p, g0);
    set_a(1'b0, 20'h00010, 16'h0000, 2'b00);
    wait_gnt(p, g1);
    wait_rv(rc, d);
    chk("bytewr_rdata", d, 16'hBE34);
    repeat (2) tick();
    we_low_cnt = 0;
    set_a(1'b1, 20'h00010, 16'hFFFF, 2'b00);
    wait_gnt(p, g0);
    repeat (N + 3) tick();
    chk("be00_no_we_pulse", we_low_cnt, 0);
    set_a(1'b0, 20'h00010, 16'h0000, 2'b00);
    wait_gnt(p, g1);
    wait_rv(rc, d);
    chk("be00_rdata", d, 16'hBE34);
    chk("b_rvalid_never", rvb_cnt, 0);

    // simultaneous requests from reset: A,B,A,B, N+3 cycles apart
    do_reset(2);
    set_a(1'b1, 20'h00012, 16'($urandom), 2'b11);
    set_b(1'b1, 20'h00013, 16'($urandom), 2'b11);
    g0 = -1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(p, g1);
      chk("tie_order", p, (i % 2 == 0) ? 1 : 2);
      if (i > 0) chk("tie_spacing", g1 - g0, N + 3);
      g0 = g1;
      if (p == 1) set_a(1'b1, 20'h00012, 16'($urandom), 2'b11);
      else        set_b(1'b1, 20'h00013, 16'($urandom), 2'b11);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (N + 3) tick();

    // reset during the ACCESS phase of a write
    rva_cnt = 0;
    rvb_cnt = 0;
    set_b(1'b1, 20'h00011, 16'hABCD, 2'b11);
    wait_gnt(p, g0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("abort_we_n", we_n, 1'b1);
    chk("abort_ce_n", ce_n, 1'b1);
    rst_n = 1'b1;
    repeat (N + 3) tick();
    chk("abort_no_rvalid", rva_cnt + rvb_cnt, 0);
    set_a(1'b0, 20'h00011, 16'h0000, 2'b00);
    set_b(1'b0, 20'h00011, 16'h0000, 2'b00);
    wait_gnt(p, g0);
    chk("abort_next_tie_a", p, 1);
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (N + 4) tick();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if (!a_req && $urandom_range(0, 2) == 0)
        set_a(1'($urandom_range(0, 1)), 20'h00010 + 20'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)));
      if (!b_req && $urandom_range(0, 2) == 0)
        set_b(1'($urandom_range(0, 1)), 20'h00010 + 20'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)));
      tick();
    end
    a_req = 1'b0;
    b_req = 1'b0;
    repeat (N + 4) tick();

    // ACCESS_CYCLES = 1 and 15 instances: read latency and data
    g1c = -1000; r1c = -2000; g15c = -1000; r15c = -2000;
    d1 = '0; d15 = '0;
    x1_req  = 1'b1;
    x15_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ev1_g)   g1c  = cyc - 1;
      if (ev15_g)  g15c = cyc - 1;
      if (ev1_rv)  begin r1c  = cyc - 1; d1  = ev1_d;  end
      if (ev15_rv) begin r15c = cyc - 1; d15 = ev15_d; end
    end
    chk("n1_rv_latency", r1c - g1c, 3);
    chk("n15_rv_latency", r15c - g15c, 17);
    chk("n1_rdata", d1, 16'hA5A5);
    chk("n15_rdata", d15, 16'h5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
